// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: shares one aes_modified core between N_REQ requesters.
// Round-robin grant, core load/start sequencing, fixed-latency capture and
// a valid/ready response channel. One job is in flight at a time.
// Optional build macro AES_SCHED_PERF_CNT_EN adds jobs_done/busy_cycles.
module aes_job_scheduler #(
  parameter int N_REQ        = 4,
  parameter int ID_W         = $clog2(N_REQ),
  parameter int CORE_LATENCY = 41
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*128-1:0] req_data,
  input  logic [N_REQ*128-1:0] req_key,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [127:0]         rsp_data,
  output logic                 busy,
  output logic                 core_rst,
  output logic                 core_start,
  output logic [127:0]         core_in,
  output logic [127:0]         core_key,
  input  logic [127:0]         core_out
`ifdef AES_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]          jobs_done,
  output logic [31:0]          busy_cycles
`endif
);

  localparam int CNT_W = $clog2(CORE_LATENCY + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t             state_r, state_nx;
  logic [ID_W-1:0]    ptr_r, ptr_nx;
  logic [CNT_W-1:0]   cnt_r, cnt_nx;
  logic [N_REQ-1:0]   grant_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic               accept_s;
  logic               rsp_valid_nx, core_rst_nx, core_start_nx, busy_nx;
  logic [ID_W-1:0]    rsp_id_nx;
  logic [127:0]       rsp_data_nx, core_in_nx, core_key_nx;

  // First valid requester at or after p, wrapping past N_REQ-1.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                               input logic [ID_W-1:0]  p);
    logic [N_REQ-1:0] g;
    logic             found;
    logic [ID_W:0]    s;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      s = {1'b0, p} + (ID_W+1)'(i);
      s = (s >= (ID_W+1)'(N_REQ)) ? s - (ID_W+1)'(N_REQ) : s;
      g[s[ID_W-1:0]] = g[s[ID_W-1:0]] | (v[s[ID_W-1:0]] & ~found);
      found          = found | v[s[ID_W-1:0]];
    end
    return g;
  endfunction

  // Binary index of a one-hot vector (zero when empty).
  function automatic logic [ID_W-1:0] onehot_idx(input logic [N_REQ-1:0] g);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ; i++) begin
      r = r | (g[i] ? ID_W'(i) : '0);
    end
    return r;
  endfunction

  // Combinational grant: only offered while idle.
  always_comb begin
    grant_s = rr_pick(req_valid, ptr_r);
    if (state_r == ST_IDLE) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  assign accept_s    = |(req_valid & req_ready);
  assign grant_idx_s = onehot_idx(req_ready);

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_nx      = state_r;
    ptr_nx        = ptr_r;
    cnt_nx        = cnt_r;
    rsp_valid_nx  = rsp_valid;
    rsp_id_nx     = rsp_id;
    rsp_data_nx   = rsp_data;
    core_in_nx    = core_in;
    core_key_nx   = core_key;
    core_rst_nx   = 1'b0;
    core_start_nx = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          core_in_nx  = req_data[grant_idx_s*128 +: 128];
          core_key_nx = req_key[grant_idx_s*128 +: 128];
          rsp_id_nx   = grant_idx_s;
          ptr_nx      = (grant_idx_s == ID_W'(N_REQ-1)) ? '0 : grant_idx_s + ID_W'(1);
          core_rst_nx = 1'b1;
          state_nx    = ST_LOAD;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_LOAD: begin
        core_start_nx = 1'b1;
        state_nx      = ST_START;
      end
      ST_START: begin
        cnt_nx   = CNT_W'(1);
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_r == CNT_W'(CORE_LATENCY)) begin
          // Core output is only meaningful in this one cycle; take it as is.
          rsp_data_nx  = core_out;
          rsp_valid_nx = 1'b1;
          state_nx     = ST_RESP;
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nx = 1'b0;
          state_nx     = ST_IDLE;
        end else begin
          state_nx = ST_RESP;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    busy_nx = (state_nx != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath and output registers; reset parks the core in reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_r      <= '0;
      cnt_r      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      core_rst   <= 1'b1;
      core_start <= 1'b0;
      core_in    <= '0;
      core_key   <= '0;
      busy       <= 1'b0;
    end else begin
      ptr_r      <= ptr_nx;
      cnt_r      <= cnt_nx;
      rsp_valid  <= rsp_valid_nx;
      rsp_id     <= rsp_id_nx;
      rsp_data   <= rsp_data_nx;
      core_rst   <= core_rst_nx;
      core_start <= core_start_nx;
      core_in    <= core_in_nx;
      core_key   <= core_key_nx;
      busy       <= busy_nx;
    end
  end

`ifdef AES_SCHED_PERF_CNT_EN
  // Performance counters; the accept cycle counts as part of the job.
  always_ff @(posedge clk) begin
    if (!rst) begin
      jobs_done   <= 32'd0;
      busy_cycles <= 32'd0;
    end else begin
      jobs_done   <= jobs_done + ((rsp_valid & rsp_ready) ? 32'd1 : 32'd0);
      busy_cycles <= busy_cycles + ((busy | accept_s) ? 32'd1 : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler with a behavioural stand-in core
// and a response scoreboard.
module tb_aes_job_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [511:0] req_data;
  logic [511:0] req_key;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [127:0] rsp_data;
  logic         busy;
  logic         core_rst;
  logic         core_start;
  logic [127:0] core_in;
  logic [127:0] core_key;
  logic [127:0] core_out;
`ifdef AES_SCHED_PERF_CNT_EN
  logic [31:0]  jobs_done;
  logic [31:0]  busy_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  typedef struct packed {
    logic [1:0]   id;
    logic [127:0] ct;
  } exp_t;
  exp_t sb_q[$];

  aes_job_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .core_rst(core_rst), .core_start(core_start),
    .core_in(core_in), .core_key(core_key), .core_out(core_out)
`ifdef AES_SCHED_PERF_CNT_EN
    , .jobs_done(jobs_done), .busy_cycles(busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Free-running cycle count used for latency and spacing measurements.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Stand-in for the encryption core: deterministic mixing function,
  // valid only 41 cycles after start, noise otherwise.
  function automatic logic [127:0] model_f(input logic [127:0] pt, input logic [127:0] k);
    return ({pt[95:0], pt[127:96]} ^ k) + {k[63:0], pt[63:0]};
  endfunction

  logic [127:0] m_in = 128'd0;
  logic [127:0] m_key = 128'd0;
  logic         m_act = 1'b0;
  int           m_cnt = 0;

  // Core model: load on core_rst, count from core_start.
  always @(posedge clk) begin
    if (core_rst) begin
      m_in  <= core_in;
      m_key <= core_key;
      m_act <= 1'b0;
      m_cnt <= 0;
    end else if (core_start) begin
      m_act <= 1'b1;
      m_cnt <= 1;
    end else if (m_act) begin
      m_cnt <= m_cnt + 1;
    end
  end

  assign core_out = (m_act && m_cnt == 41) ? model_f(m_in, m_key)
                  : (128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C ^ {96'd0, 32'(m_cnt)});

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) cyc();
    rst = 1'b1;
    cyc();
  endtask

  // Wait (bounded) for an accept in the current cycle; push expectation.
  task automatic wait_accept(output int id, output int acyc);
    int n;
    n  = 0;
    id = -1;
    while ((req_valid & req_ready) == 4'b0000 && n < 200) begin
      cyc();
      n++;
    end
    chk("accept_seen", 128'(n < 200), 128'd1);
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i] && req_valid[i]) id = i;
    end
    acyc = cyc_cnt;
    if (id >= 0) sb_q.push_back({2'(id), model_f(req_data[id*128 +: 128], req_key[id*128 +: 128])});
  endtask

  // Wait (bounded) for rsp_valid; check latency and scoreboard entry.
  task automatic expect_response(input int acyc, input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!rsp_valid && n < 200) begin
      cyc();
      n++;
    end
    chk({tag, "_rsp_seen"}, 128'(n < 200), 128'd1);
    chk({tag, "_latency"}, 128'(cyc_cnt - acyc), 128'd44);
    chk({tag, "_sb_nonempty"}, 128'(sb_q.size() > 0), 128'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_rsp_id"}, 128'(rsp_id), 128'(e.id));
      chk({tag, "_rsp_data"}, rsp_data, e.ct);
    end
  endtask

  initial begin
    int id, acyc, prev, hs, bad;
    logic [1:0]   h_id;
    logic [127:0] h_data;

    rst = 1'b0; req_valid = 4'b0000; req_data = '0; req_key = '0; rsp_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_core_rst", 128'(core_rst), 128'd1);
    chk("rst_core_start", 128'(core_start), 128'd0);
    chk("rst_rsp_id", 128'(rsp_id), 128'd0);
    chk("rst_rsp_data", rsp_data, 128'd0);
    chk("rst_core_in", core_in, 128'd0);
    chk("rst_core_key", core_key, 128'd0);
    rst = 1'b1;
    cyc();
    chk("idle_core_rst", 128'(core_rst), 128'd0);

    // Single job from requester 2.
    req_data[2*128 +: 128] = 128'h3243f6a8885a308d313198a2e0370734;
    req_key[2*128 +: 128]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    req_valid = 4'b0100;
    #1;
    chk("t1_req_ready", 128'(req_ready), 128'h4);
    wait_accept(id, acyc);
    cyc(); req_valid = 4'b0000;
    chk("t1_core_rst_a1", 128'(core_rst), 128'd1);
    chk("t1_core_start_a1", 128'(core_start), 128'd0);
    cyc();
    chk("t1_core_rst_a2", 128'(core_rst), 128'd0);
    chk("t1_core_start_a2", 128'(core_start), 128'd1);
    chk("t1_core_in", core_in, 128'h3243f6a8885a308d313198a2e0370734);
    chk("t1_core_key", core_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    cyc();
    chk("t1_core_start_a3", 128'(core_start), 128'd0);
    expect_response(acyc, "t1");
    chk("t1_rsp_id_is_2", 128'(rsp_id), 128'd2);
    cyc();
    chk("t1_rsp_valid_clear", 128'(rsp_valid), 128'd0);
    chk("t1_busy_clear", 128'(busy), 128'd0);

    // Round robin with all requesters valid.
    do_reset(2);
    for (int k = 0; k < 4; k++) begin
      req_data[k*128 +: 128] = {4{32'h1111_1111 * 32'(k + 1)}};
      req_key[k*128 +: 128]  = {4{32'h0F0F_0000 + 32'(k)}};
    end
    req_valid = 4'b1111;
    #1;
    prev = 0;
    for (int j = 0; j < 5; j++) begin
      wait_accept(id, acyc);
      chk("t2_grant_order", 128'(id), 128'(j % 4));
      if (j > 0) chk("t2_spacing", 128'(acyc - prev), 128'd45);
      prev = acyc;
      cyc();
      expect_response(acyc, "t2");
    end
    req_valid = 4'b0000;
    cyc();

    // Backpressure: pointer is 1; only requester 3 asks first.
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    #1;
    wait_accept(id, acyc);
    chk("t3_grant", 128'(id), 128'd3);
    cyc(); req_valid = 4'b1111;
    expect_response(acyc, "t3");
    h_id = rsp_id; h_data = rsp_data;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (rsp_valid !== 1'b1 || rsp_id !== h_id || rsp_data !== h_data ||
          req_ready !== 4'b0000 || core_start !== 1'b0) bad++;
    end
    chk("t3_hold_stable", 128'(bad), 128'd0);
    rsp_ready = 1'b1;
    hs = cyc_cnt;
    wait_accept(id, acyc);
    chk("t3_next_grant_delay", 128'(acyc - hs), 128'd1);
    chk("t3_next_grant_id", 128'(id), 128'd0);
    cyc(); req_valid = 4'b0000;
    expect_response(acyc, "t3b");
    cyc();

    // Reset mid-job at counter 20 (cycle A+22).
    req_valid = 4'b0100;
    #1;
    wait_accept(id, acyc);
    cyc(); req_valid = 4'b0000;
    repeat (21) cyc();
    rst = 1'b0;
    cyc();
    chk("t4_core_rst_in_reset", 128'(core_rst), 128'd1);
    chk("t4_busy_in_reset", 128'(busy), 128'd0);
    chk("t4_rsp_valid_in_reset", 128'(rsp_valid), 128'd0);
    rst = 1'b1;
    sb_q.delete();
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (rsp_valid !== 1'b0 || core_start !== 1'b0) bad++;
    end
    chk("t4_no_response", 128'(bad), 128'd0);
    req_valid = 4'b1111;
    #1;
    chk("t4_ptr_zero", 128'(req_ready), 128'h1);
    req_valid = 4'b0010;
    #1;
    chk("t4_req1_ready", 128'(req_ready), 128'h2);
    wait_accept(id, acyc);
    cyc(); req_valid = 4'b0000;
    chk("t4_core_rst_a1", 128'(core_rst), 128'd1);
    cyc();
    chk("t4_core_start_a2", 128'(core_start), 128'd1);
    expect_response(acyc, "t4");
    cyc();

    // Zero data from requester 3 with pointer at 3, then wrap to 0.
    req_valid = 4'b0100;
    #1;
    wait_accept(id, acyc);
    cyc(); req_valid = 4'b0000;
    expect_response(acyc, "t5pre");
    cyc();
    req_data[3*128 +: 128] = 128'd0;
    req_key[3*128 +: 128]  = 128'd0;
    req_valid = 4'b1001;
    #1;
    chk("t5_grant3", 128'(req_ready), 128'h8);
    wait_accept(id, acyc);
    prev = acyc;
    cyc();
    expect_response(acyc, "t5z");
    chk("t5_zero_ct", rsp_data, 128'd0);
    wait_accept(id, acyc);
    chk("t5_wrap_grant0", 128'(id), 128'd0);
    chk("t5_spacing", 128'(acyc - prev), 128'd45);
    cyc(); req_valid = 4'b0000;
    expect_response(acyc, "t5w");
    cyc();

`ifdef AES_SCHED_PERF_CNT_EN
    // Performance counters over three back-to-back jobs.
    do_reset(2);
    chk("pc_rst_jobs", 128'(jobs_done), 128'd0);
    req_valid = 4'b0010;
    #1;
    for (int j = 0; j < 3; j++) begin
      wait_accept(id, acyc);
      cyc();
      if (j == 2) req_valid = 4'b0000;
      expect_response(acyc, "pc");
    end
    cyc();
    chk("pc_jobs_done", 128'(jobs_done), 128'd3);
    chk("pc_busy_cycles", 128'(busy_cycles), 128'd135);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
